dds_multi_core: RTL and testbench

Multi-channel, runtime-configurable DDS waveform core. It generalises the single-channel fixed-wave DDS into CH_NUM independent phase accumulators. Each channel has its own tuning word, phase offset, waveform select, amplitude attenuation and linear frequency sweep. It is driven by the control/key-management logic through a simple register-write port, and feeds DAC output pins and the display path.

---
 rtl/dds_multi_core_if.sv | 26 ++
 rtl/dds_multi_core.sv | 152 +++++++++++++++
 tb/tb_dds_multi_core.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dds_multi_core_if.sv
// Configuration bus and sample outputs between the control logic and the multi-channel DDS core.
interface dds_multi_core_if #(
  parameter int unsigned CH_NUM = 2,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 8
);
  localparam int unsigned ChW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                    cfg_wr;
  logic [ChW-1:0]          cfg_ch;
  logic [2:0]              cfg_addr;
  logic [ACC_W-1:0]        cfg_data;
  logic                    phase_sync;
  logic [CH_NUM*OUT_W-1:0] wave_out;
  logic [CH_NUM-1:0]       wrap_pulse;

  modport master (
    output cfg_wr, cfg_ch, cfg_addr, cfg_data, phase_sync,
    input  wave_out, wrap_pulse
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_addr, cfg_data, phase_sync,
    output wave_out, wrap_pulse
  );
endinterface

// File: rtl/dds_multi_core.sv
// Multi-channel DDS: per-channel phase accumulator, linear FTW sweep, waveform shaping and
// centred amplitude attenuation, with a 2-stage output pipeline.
module dds_multi_core #(
  parameter int unsigned CH_NUM    = 2,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned SWEEP_DIV = 1000
) (
  input logic              clk,
  input logic              rst_n,
  dds_multi_core_if.slave  bus
);
  localparam int unsigned CntW = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [OUT_W-1:0] Mid = {1'b1, {(OUT_W-1){1'b0}}};

  // Configuration registers
  logic [ACC_W-1:0] ftw_q    [CH_NUM];
  logic [ACC_W-1:0] ftw_d    [CH_NUM];
  logic [ACC_W-1:0] poff_q   [CH_NUM];
  logic [ACC_W-1:0] poff_d   [CH_NUM];
  logic [5:0]       mode_q   [CH_NUM];
  logic [5:0]       mode_d   [CH_NUM];
  logic [ACC_W-1:0] swstop_q [CH_NUM];
  logic [ACC_W-1:0] swstop_d [CH_NUM];
  logic [ACC_W-1:0] swstep_q [CH_NUM];
  logic [ACC_W-1:0] swstep_d [CH_NUM];

  // Datapath state
  logic [ACC_W-1:0] acc_q     [CH_NUM];
  logic [ACC_W-1:0] acc_d     [CH_NUM];
  logic [ACC_W-1:0] ftw_cur_q [CH_NUM];
  logic [ACC_W-1:0] ftw_cur_d [CH_NUM];
  logic [OUT_W-1:0] v_q       [CH_NUM];
  logic [OUT_W-1:0] v_d       [CH_NUM];
  logic [1:0]       s_q       [CH_NUM];
  logic [1:0]       s_d       [CH_NUM];
  logic [OUT_W-1:0] out_q     [CH_NUM];
  logic [OUT_W-1:0] out_d     [CH_NUM];
  logic [CH_NUM-1:0] en1_q, en1_d;
  logic [CH_NUM-1:0] wrap_q, wrap_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Combinational helpers
  logic              tick;
  logic [CH_NUM-1:0] wr_sel;
  logic [ACC_W:0]    acc_sum [CH_NUM];
  logic [ACC_W:0]    sw_nxt  [CH_NUM];
  logic [ACC_W-1:0]  p       [CH_NUM];
  logic [OUT_W-1:0]  t       [CH_NUM];

  always_comb begin
    tick  = (cnt_q == CntW'(SWEEP_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    en1_d  = '0;
    wrap_d = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      // Indices >= CH_NUM never match, so such writes drop out here.
      wr_sel[k]   = bus.cfg_wr && (int'(bus.cfg_ch) == k);
      ftw_d[k]    = ftw_q[k];
      poff_d[k]   = poff_q[k];
      mode_d[k]   = mode_q[k];
      swstop_d[k] = swstop_q[k];
      swstep_d[k] = swstep_q[k];
      if (wr_sel[k]) begin
        case (bus.cfg_addr)
          3'd0:    ftw_d[k]    = bus.cfg_data;
          3'd1:    poff_d[k]   = bus.cfg_data;
          3'd2:    mode_d[k]   = bus.cfg_data[5:0];
          3'd3:    swstop_d[k] = bus.cfg_data;
          3'd4:    swstep_d[k] = bus.cfg_data;
          default: ;
        endcase
      end

      // Sweep: an FTW write beats a coincident tick; a zero step never reloads.
      sw_nxt[k]    = {1'b0, ftw_cur_q[k]} + {1'b0, swstep_q[k]};
      ftw_cur_d[k] = ftw_cur_q[k];
      if (wr_sel[k] && bus.cfg_addr == 3'd0) begin
        ftw_cur_d[k] = bus.cfg_data;
      end else if (!mode_q[k][5]) begin
        ftw_cur_d[k] = ftw_q[k];
      end else if (tick && swstep_q[k] != '0) begin
        if (sw_nxt[k] > {1'b0, swstop_q[k]}) ftw_cur_d[k] = ftw_q[k];
        else                                  ftw_cur_d[k] = sw_nxt[k][ACC_W-1:0];
      end

      acc_sum[k] = {1'b0, acc_q[k]} + {1'b0, ftw_cur_q[k]};
      if (bus.phase_sync || !mode_q[k][4]) begin
        acc_d[k] = '0;
      end else begin
        acc_d[k]  = acc_sum[k][ACC_W-1:0];
        wrap_d[k] = acc_sum[k][ACC_W];
      end

      // Stage 1: phase offset and wave shaping; shift and enable travel with the sample.
      p[k] = acc_q[k] + poff_q[k];
      t[k] = p[k][ACC_W-1 -: OUT_W];
      case (mode_q[k][1:0])
        2'd0:    v_d[k] = t[k];
        2'd1:    v_d[k] = t[k][OUT_W-1] ? ~(t[k] << 1) : (t[k] << 1);
        2'd2:    v_d[k] = t[k][OUT_W-1] ? '0 : '1;
        default: v_d[k] = ~t[k];
      endcase
      s_d[k]   = mode_q[k][3:2];
      en1_d[k] = mode_q[k][4];

      // Stage 2: attenuate around mid-scale.
      out_d[k] = en1_q[k] ? (v_q[k] >> s_q[k]) + (Mid - (Mid >> s_q[k])) : Mid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      en1_q  <= '0;
      wrap_q <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        ftw_q[k]     <= '0;
        poff_q[k]    <= '0;
        mode_q[k]    <= '0;
        swstop_q[k]  <= '0;
        swstep_q[k]  <= '0;
        acc_q[k]     <= '0;
        ftw_cur_q[k] <= '0;
        v_q[k]       <= '0;
        s_q[k]       <= '0;
        out_q[k]     <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      en1_q  <= en1_d;
      wrap_q <= wrap_d;
      for (int k = 0; k < CH_NUM; k++) begin
        ftw_q[k]     <= ftw_d[k];
        poff_q[k]    <= poff_d[k];
        mode_q[k]    <= mode_d[k];
        swstop_q[k]  <= swstop_d[k];
        swstep_q[k]  <= swstep_d[k];
        acc_q[k]     <= acc_d[k];
        ftw_cur_q[k] <= ftw_cur_d[k];
        v_q[k]       <= v_d[k];
        s_q[k]       <= s_d[k];
        out_q[k]     <= out_d[k];
      end
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_out
    assign bus.wave_out[k*OUT_W +: OUT_W] = out_q[k];
  end
  assign bus.wrap_pulse = wrap_q;
endmodule

// File: tb/tb_dds_multi_core.sv
// Directed bench for dds_multi_core: saw/triangle/square shaping, sweep, phase sync and reset.
module tb_dds_multi_core;
  localparam int unsigned CH_NUM    = 2;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned SWEEP_DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dds_multi_core_if #(.CH_NUM(CH_NUM), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  dds_multi_core #(
    .CH_NUM   (CH_NUM),
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .SWEEP_DIV(SWEEP_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] saw_tbl [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};
  logic [7:0] tri_tbl [8] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample and drive 1 ns after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic ch, input logic [2:0] addr, input logic [31:0] data);
    bus.cfg_wr   = 1'b1;
    bus.cfg_ch   = ch;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    step(1);
    bus.cfg_wr = 1'b0;
  endtask

  function automatic logic [7:0] ch_out(input int ch);
    return bus.wave_out[ch*8 +: 8];
  endfunction

  initial begin
    int n9f;
    bus.cfg_wr     = 1'b0;
    bus.cfg_ch     = 1'b0;
    bus.cfg_addr   = 3'd0;
    bus.cfg_data   = '0;
    bus.phase_sync = 1'b0;
    rst_n          = 1'b0;
    step(2);
    chk("reset_wave", 64'(bus.wave_out), 64'h0000);
    chk("reset_wrap", 64'(bus.wrap_pulse), 64'h0);
    rst_n = 1'b1;

    // Saw on ch0, quarter-turn per cycle; ch1 idle at mid-scale.
    wr(1'b0, 3'd0, 32'h4000_0000);
    wr(1'b0, 3'd2, 32'h10);
    step(2);
    for (int i = 0; i < 8; i++) begin
      chk("saw_ch0", 64'(ch_out(0)), 64'(saw_tbl[i % 4]));
      chk("saw_wrap0", 64'(bus.wrap_pulse[0]), 64'((i % 4) == 2));
      chk("idle_ch1", 64'(ch_out(1)), 64'h80);
      step(1);
    end

    // Triangle on ch1, eighth-turn per cycle.
    wr(1'b1, 3'd0, 32'h2000_0000);
    wr(1'b1, 3'd2, 32'h11);
    step(2);
    for (int i = 0; i < 16; i++) begin
      chk("tri_ch1", 64'(ch_out(1)), 64'(tri_tbl[i % 8]));
      step(1);
    end

    // Square with shift 2 on ch0: only 0x9F / 0x60, half the time each.
    wr(1'b0, 3'd2, 32'h1A);
    step(2);
    n9f = 0;
    for (int i = 0; i < 8; i++) begin
      chk("sq_ch0_level", 64'(ch_out(0) == 8'h9F || ch_out(0) == 8'h60), 64'h1);
      if (ch_out(0) == 8'h9F) n9f++;
      step(1);
    end
    chk("sq_ch0_duty", 64'(n9f), 64'd4);

    // Phase sync with ch1 offset by half a turn.
    wr(1'b0, 3'd0, 32'h1000_0000);
    wr(1'b0, 3'd2, 32'h10);
    wr(1'b1, 3'd0, 32'h1000_0000);
    wr(1'b1, 3'd1, 32'h8000_0000);
    wr(1'b1, 3'd2, 32'h10);
    bus.phase_sync = 1'b1;
    step(1);
    bus.phase_sync = 1'b0;
    chk("sync_wrap", 64'(bus.wrap_pulse), 64'h0);
    step(2);
    for (int i = 0; i < 8; i++) begin
      chk("sync_ch0", 64'(ch_out(0)), 64'(8'(i * 16)));
      chk("sync_ch1", 64'(ch_out(1)), 64'(8'(i * 16) ^ 8'h80));
      step(1);
    end

    // Sweep: counter restarts at reset, so ticks land on edges 4, 8, 12, ... after it.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    wr(1'b0, 3'd0, 32'h100);
    wr(1'b0, 3'd4, 32'h100);
    wr(1'b0, 3'd3, 32'h400);
    wr(1'b0, 3'd2, 32'h30);
    chk("sweep_e4", 64'(dut.ftw_cur_q[0]), 64'h100);
    step(3);
    chk("sweep_e7", 64'(dut.ftw_cur_q[0]), 64'h100);
    step(1);
    chk("sweep_e8", 64'(dut.ftw_cur_q[0]), 64'h200);
    step(4);
    chk("sweep_e12", 64'(dut.ftw_cur_q[0]), 64'h300);
    step(4);
    chk("sweep_e16", 64'(dut.ftw_cur_q[0]), 64'h400);
    step(4);
    chk("sweep_wrap_e20", 64'(dut.ftw_cur_q[0]), 64'h100);
    step(3);
    wr(1'b0, 3'd0, 32'h180);
    chk("sweep_ftw_on_tick", 64'(dut.ftw_cur_q[0]), 64'h180);
    step(4);
    chk("sweep_after_rewrite", 64'(dut.ftw_cur_q[0]), 64'h280);

    // Reset mid-sweep clears everything; channels come back disabled.
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("midreset_wave", 64'(bus.wave_out), 64'h0000);
    chk("midreset_wrap", 64'(bus.wrap_pulse), 64'h0);
    chk("midreset_ftwcur", 64'(dut.ftw_cur_q[0]), 64'h0);
    rst_n = 1'b1;
    step(2);
    chk("postreset_mid", 64'(bus.wave_out), 64'h8080);

    // Unused address 6 must not alias MODE.
    wr(1'b0, 3'd6, 32'h10);
    step(3);
    chk("addr6_ignored", 64'(ch_out(0)), 64'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
